hires_video_shifter: RTL and testbench
======================================

HIRES_VIDEO_SHIFTER -- requirements
Module: hires_video_shifter

Interface
REQ-001 SHALL provide clock_14_i, input, 1 bit: 14.31818 MHz master clock; every register is clocked on its rising edge.
REQ-002 SHALL provide reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL provide ld194_i, input, 1 bit: active-low load strobe from the timing generator, low for exactly one 14M cycle per 14.
REQ-004 SHALL provide data_i, input, 8 bits: video RAM byte. Bits [6:0] are dots, LSB first. Bit 7 is the half-dot delay flag.
REQ-005 SHALL provide blank_i, input, 1 bit: composite blanking for the byte being fetched.
REQ-006 SHALL provide hbl_i, input, 1 bit: horizontal blanking.
REQ-007 SHALL provide vbl_i, input, 1 bit: vertical blanking.
REQ-008 SHALL provide video_o, output, 1 bit, registered: serial monochrome dot stream at 14M resolution.
REQ-009 SHALL provide blank_o, output, 1 bit, registered: blanking aligned to video_o.
REQ-010 SHALL provide byte_count_o, output, 6 bits: visible bytes loaded on the current line.
REQ-011 SHALL provide frame_o, output, 1 bit: one-cycle pulse marking the start of vertical blanking.

Function
REQ-012 Load edge: an edge with ld194_i==0. At a load edge the block SHALL latch:
- shift_r <= data_i[6:0]
- delay_r <= data_i[7]
- blank_r <= blank_i
- phase_r <= 0
REQ-013 Non-load edges: phase_r SHALL toggle on every non-load edge. shift_r SHALL shift right one place, filling with 0, only on a non-load edge where phase_r==1.
REQ-014 Dot stream register: nd_r SHALL register shift_r[0] on every edge (the non-delayed dot stream).
REQ-015 Output: on every edge, video_o SHALL take the value
- 0 when blank_r==1
- else nd_r when delay_r==1 (delay feature compiled in)
- else shift_r[0].
REQ-016 Latency: for a byte loaded at edge N with delay_r==0, dot k (k=0..6) SHALL appear on video_o during the two cycles following edges N+1+2k and N+2+2k.
REQ-017 Delay timing: with delay_r==1, each dot SHALL appear one 14M cycle later than in REQ-016. The cycle following edge N+1 SHALL show the preceding byte's last shifted-out dot.
REQ-018 Blank output: blank_o SHALL register blank_r on every edge, so it stays aligned with video_o.
REQ-019 Early load: if ld194_i goes low before 7 dots have shifted out, the new load SHALL win. Remaining dots are discarded.
REQ-020 Missing load: if no load occurs for more than 14 edges, shifting SHALL continue and video_o SHALL output 0 dots.
REQ-021 Byte counter, priority order at each load edge:
- hbl_i==1: byte_count_o SHALL clear to 0.
- else blank_i==0: byte_count_o SHALL increment, saturating at 63.
- otherwise it SHALL hold.
REQ-022 Frame pulse: frame_o SHALL be high for exactly one cycle on the edge after vbl_i is first sampled 1 following a 0 sample.
REQ-023 Simultaneous events: load, hbl_i and vbl_i asserted on the same edge SHALL each be processed independently per REQ-012, REQ-021 and REQ-022.

Reset
REQ-024 While reset_i==1, the following SHALL be 0 immediately, independent of the clock:
- shift_r, delay_r, phase_r, nd_r
- the previous-vbl register
- video_o, byte_count_o, frame_o
REQ-025 While reset_i==1, blank_r and blank_o SHALL be 1.
REQ-026 After reset_i deasserts, no dot SHALL be emitted before the first load edge. A reset asserted mid-byte SHALL discard that byte.
REQ-027 Reset deassertion with vbl_i already 1 SHALL NOT produce a frame_o pulse.

Configuration
REQ-028 Macro HIRES_HALF_DOT_DELAY_EN SHALL control the half-dot delay.
- Defined: delay_r and REQ-015/REQ-017 delay behaviour are implemented.
- Undefined: delay_r is not implemented, data_i[7] is ignored, and video_o always follows REQ-016 timing.

Verification
REQ-029 Reset: assert reset_i mid-byte -> video_o=0, blank_o=1, byte_count_o=0 immediately. No dots until the next load.
REQ-030 Basic shift: load data_i=8'h55, blank_i=0 at edge N -> video_o pattern 1,1,0,0,1,1,0,0,1,1,0,0,1,1 over edges N+1..N+14.
REQ-031 Half-dot delay: load 8'h7F then 8'h81, 14 edges apart (macro defined) -> second byte gives 1 (previous last dot), 1,1, then 0 for 12 cycles. With the macro undefined -> 1,1 then 0 for 12 cycles.
REQ-032 Blanking: blank_i=1 at a load with data_i=8'hFF -> video_o=0 and blank_o=1 for the 14 cycles after the load.
REQ-033 Byte counter: 40 visible loads then hbl_i=1 -> byte_count_o=40, then 0. 70 visible loads without hbl -> saturates at 63.
REQ-034 Frame pulse: vbl_i 0->1 held for 1000 cycles -> exactly one frame_o pulse. Early load at 8 edges -> new byte's dot0 at edge load+1.

Source files
------------

// File: rtl/hires_video_shifter.sv
// Hi-res video shifter: serialises 7-dot video bytes at 14M, tracks visible bytes per line and flags frame start.
// Optional half-dot delay (data_i[7]) is compiled in with `define HIRES_HALF_DOT_DELAY_EN.
`timescale 1ns/1ps
module hires_video_shifter (
  input  logic       clock_14_i,
  input  logic       reset_i,
  input  logic       ld194_i,
  input  logic [7:0] data_i,
  input  logic       blank_i,
  input  logic       hbl_i,
  input  logic       vbl_i,
  output logic       video_o,
  output logic       blank_o,
  output logic [5:0] byte_count_o,
  output logic       frame_o
);

  logic [6:0] r_shift;
  logic       r_phase;
  logic       r_blank;
  logic       r_vbl_prev;
  logic       r_vbl_vld;
  logic       w_load;
  logic       w_dot;

  assign w_load = ~ld194_i;

`ifdef HIRES_HALF_DOT_DELAY_EN
  logic r_delay;
  logic r_nd;

  always_ff @(posedge clock_14_i or posedge reset_i) begin
    if (reset_i) begin
      r_delay <= 1'b0;
      r_nd    <= 1'b0;
    end else begin
      if (w_load) r_delay <= data_i[7];
      r_nd <= r_shift[0];
    end
  end

  // Delayed bytes take the dot one 14M cycle late from the nd stream.
  assign w_dot = r_delay ? r_nd : r_shift[0];
`else
  logic w_unused_delay_flag;
  assign w_unused_delay_flag = data_i[7];
  assign w_dot = r_shift[0];
`endif

  always_ff @(posedge clock_14_i or posedge reset_i) begin
    if (reset_i) begin
      r_shift <= 7'd0;
      r_phase <= 1'b0;
      r_blank <= 1'b1;
      video_o <= 1'b0;
      blank_o <= 1'b1;
    end else begin
      if (w_load) begin
        r_shift <= data_i[6:0];
        r_blank <= blank_i;
        r_phase <= 1'b0;
      end else begin
        r_phase <= ~r_phase;
        if (r_phase) r_shift <= {1'b0, r_shift[6:1]};
      end
      video_o <= r_blank ? 1'b0 : w_dot;
      blank_o <= r_blank;
    end
  end

  always_ff @(posedge clock_14_i or posedge reset_i) begin
    if (reset_i) begin
      byte_count_o <= 6'd0;
    end else if (w_load) begin
      if (hbl_i)
        byte_count_o <= 6'd0;
      else if (!blank_i && byte_count_o != 6'd63)
        byte_count_o <= byte_count_o + 6'd1;
    end
  end

  // r_vbl_vld suppresses a false edge when reset releases with vbl_i already high.
  always_ff @(posedge clock_14_i or posedge reset_i) begin
    if (reset_i) begin
      r_vbl_prev <= 1'b0;
      r_vbl_vld  <= 1'b0;
      frame_o    <= 1'b0;
    end else begin
      r_vbl_prev <= vbl_i;
      r_vbl_vld  <= 1'b1;
      frame_o    <= vbl_i & ~r_vbl_prev & r_vbl_vld;
    end
  end

endmodule

// File: tb/tb_hires_video_shifter.sv
// Directed bench for hires_video_shifter: shifting, delay, blanking, byte counter, frame pulse, reset.
`timescale 1ns/1ps
module tb_hires_video_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b1;
  logic [7:0] dat = 8'h00;
  logic       blk = 1'b0;
  logic       hbl = 1'b0;
  logic       vbl = 1'b0;
  logic       video;
  logic       blank_out;
  logic [5:0] bcnt;
  logic       frame;

  int n_total = 0;
  int n_bad   = 0;

  hires_video_shifter dut (
    .clock_14_i  (clk),
    .reset_i     (rst),
    .ld194_i     (ld),
    .data_i      (dat),
    .blank_i     (blk),
    .hbl_i       (hbl),
    .vbl_i       (vbl),
    .video_o     (video),
    .blank_o     (blank_out),
    .byte_count_o(bcnt),
    .frame_o     (frame)
  );

  always #35 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic l, input logic [7:0] d, input logic b, input logic h, input logic v);
    ld  = l;
    dat = d;
    blk = b;
    hbl = h;
    vbl = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] dv;
    int pulses;
    logic exp_bit;

    #100;
    check("rst_video", video, 0);
    check("rst_blank", blank_out, 1);
    check("rst_count", bcnt, 0);
    check("rst_frame", frame, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h00, 0, 0, 0);
      check("no_dot_before_load", video, 0);
    end

    // Reset mid-byte
    step(0, 8'h7F, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 8'h00, 0, 0, 0);
    check("pre_rst_dot", video, 1);
    check("pre_rst_count", bcnt, 1);
    #10 rst = 1'b1;
    #1;
    check("midrst_video", video, 0);
    check("midrst_blank", blank_out, 1);
    check("midrst_count", bcnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h00, 0, 0, 0);
      check("post_rst_no_dot", video, 0);
    end

    // Basic shift of 0x55
    dv = 8'h55;
    step(0, dv, 0, 0, 0);
    for (int j = 1; j <= 14; j++) begin
      step(1, 8'h00, 0, 0, 0);
      check($sformatf("shift55_e%0d", j), video, dv[(j-1)/2]);
    end

    // Half-dot delay: 0x7F then 0x81
    step(0, 8'h7F, 0, 0, 0);
    for (int j = 1; j < 14; j++) step(1, 8'h00, 0, 0, 0);
    step(0, 8'h81, 0, 0, 0);
    for (int j = 1; j <= 14; j++) begin
      step(1, 8'h00, 0, 0, 0);
`ifdef HIRES_HALF_DOT_DELAY_EN
      exp_bit = (j <= 3);
`else
      exp_bit = (j <= 2);
`endif
      check($sformatf("halfdot_e%0d", j), video, exp_bit);
    end

    // Blanked byte
    step(0, 8'hFF, 1, 0, 0);
    for (int j = 1; j <= 14; j++) begin
      step(1, 8'h00, 0, 0, 0);
      check($sformatf("blank_e%0d", j), {video, blank_out}, 2'b01);
    end

    // Byte counter
    step(0, 8'h00, 0, 1, 0);
    check("cnt_clear", bcnt, 0);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 0, 0, 0);
    check("cnt_40", bcnt, 40);
    step(0, 8'h00, 0, 1, 0);
    check("cnt_hbl", bcnt, 0);
    for (int i = 0; i < 70; i++) step(0, 8'h00, 0, 0, 0);
    check("cnt_sat", bcnt, 63);
    step(0, 8'h00, 1, 0, 0);
    check("cnt_hold_blank", bcnt, 63);
    step(1, 8'h00, 0, 1, 0);
    check("cnt_hbl_noload", bcnt, 63);

    // Early load discards remaining dots
    step(0, 8'h7F, 0, 0, 0);
    for (int j = 1; j < 8; j++) step(1, 8'h00, 0, 0, 0);
    step(0, 8'h01, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    check("early_dot0_a", video, 1);
    step(1, 8'h00, 0, 0, 0);
    check("early_dot0_b", video, 1);
    for (int j = 3; j <= 8; j++) begin
      step(1, 8'h00, 0, 0, 0);
      check($sformatf("early_discard_e%0d", j), video, 0);
    end

    // Missing load
    step(0, 8'h7F, 0, 0, 0);
    for (int j = 1; j <= 30; j++) begin
      step(1, 8'h00, 0, 0, 0);
      if (j == 14) check("miss_last_dot", video, 1);
      if (j == 20 || j == 30) check($sformatf("miss_e%0d", j), video, 0);
    end

    // Frame pulse
    for (int i = 0; i < 3; i++) step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 1);
    check("frame_edge", frame, 1);
    pulses = int'(frame);
    for (int i = 1; i < 1000; i++) begin
      step(1, 8'h00, 0, 0, 1);
      pulses += int'(frame);
    end
    check("frame_once", pulses, 1);

    // Reset released with vbl high
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 8'h00, 0, 0, 1);
      pulses += int'(frame);
    end
    check("frame_none_after_rst", pulses, 0);

    // Simultaneous load, hbl and vbl rise
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("sim_pre_count", bcnt, 2);
    step(0, 8'h01, 0, 1, 1);
    check("sim_count", bcnt, 0);
    check("sim_frame", frame, 1);
    step(1, 8'h00, 0, 0, 1);
    check("sim_dot0", video, 1);
    check("sim_frame_off", frame, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
